// File: rtl/video_pattern_src_pkg.sv
// rtl/video_pattern_src_pkg.sv - shared mode encodings, bar colour table and Gray helpers
`timescale 1ns/1ps
package video_pattern_src_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef enum logic {
    TG_IDLE = 1'b0,
    TG_RUN  = 1'b1
  } tg_state_e;

  // Gray helpers work on a fixed wide word; callers zero-extend and truncate.
  localparam int GRAY_W = 16;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0: return 24'hFFFFFF;
      3'd1: return 24'hFFFF00;
      3'd2: return 24'h00FFFF;
      3'd3: return 24'h00FF00;
      3'd4: return 24'hFF00FF;
      3'd5: return 24'hFF0000;
      3'd6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/video_pattern_src_if.sv
// rtl/video_pattern_src_if.sv - memory-side read port of the pattern source
`timescale 1ns/1ps
interface video_pattern_src_if #(
  parameter int DW      = 24,
  parameter int FIFO_AW = 8
);
  logic               rd_req;
  logic [DW-1:0]      rd_data;
  logic               rd_sof;
  logic [FIFO_AW:0]   rd_usedw;
  logic               burst_rdy;

  modport master (input rd_req, output rd_data, output rd_sof, output rd_usedw, output burst_rdy);
  modport slave  (output rd_req, input rd_data, input rd_sof, input rd_usedw, input burst_rdy);
endinterface

// File: rtl/video_pattern_src_pix_async_fifo.sv
// rtl/video_pattern_src_pix_async_fifo.sv - dual-clock FIFO with Gray-coded pointers
`timescale 1ns/1ps
module pix_async_fifo
  import video_pattern_src_pkg::*;
#(
  parameter int W  = 25,
  parameter int AW = 4
) (
  input  logic          wr_clk,
  input  logic          wr_rstn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          wr_full,
  input  logic          rd_clk,
  input  logic          rd_rstn,
  input  logic          rd_req,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   rd_usedw
);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [2**AW];
  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, rq1_q, rq2_q;
  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d, wq1_q, wq2_q;
  logic [PW-1:0] usedw_q, usedw_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          wr_push, rd_pop, rd_empty;

  // Full compares against the synchronised (stale) read pointer, so it can only over-report.
  always_comb begin
    wr_full = (wgray_q == {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]});
    wr_push = wr_en && !wr_full;
    wbin_d  = wbin_q + PW'(wr_push);
    wgray_d = PW'(bin2gray(GRAY_W'(wbin_d)));
  end

  // Write pointer registers and read-pointer synchroniser.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rgray_q;
      rq2_q   <= rq1_q;
    end
  end

  // Storage array carries no reset; the pointers define what is valid.
  always_ff @(posedge wr_clk) begin
    if (wr_push) mem[wbin_q[AW-1:0]] <= wr_data;
  end

  // usedw is taken after this cycle's pop so it never exceeds the true fill level.
  always_comb begin
    rd_empty = (usedw_q == '0);
    rd_pop   = rd_req && !rd_empty;
    rbin_d   = rbin_q + PW'(rd_pop);
    rgray_d  = PW'(bin2gray(GRAY_W'(rbin_d)));
    usedw_d  = PW'(gray2bin(GRAY_W'(wq2_q))) - rbin_d;
    rdata_d  = rd_pop ? mem[rbin_q[AW-1:0]] : rdata_q;
  end

  // Read pointer, output register and write-pointer synchroniser.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      wq1_q   <= '0;
      wq2_q   <= '0;
      usedw_q <= '0;
      rdata_q <= '0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      wq1_q   <= wgray_q;
      wq2_q   <= wq1_q;
      usedw_q <= usedw_d;
      rdata_q <= rdata_d;
    end
  end

  assign rd_data  = rdata_q;
  assign rd_usedw = usedw_q;
endmodule

// File: rtl/video_pattern_src.sv
// rtl/video_pattern_src.sv - test pattern generator feeding a dual-clock pixel FIFO
`timescale 1ns/1ps
module video_pattern_src
  import video_pattern_src_pkg::*;
#(
  parameter int DW        = 24,
  parameter int H_ACT     = 1280,
  parameter int H_BLANK   = 370,
  parameter int V_ACT     = 720,
  parameter int V_BLANK   = 30,
  parameter int FIFO_AW   = 8,
  parameter int BURST_LEN = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rd_clk,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [DW-1:0]       solid_color,
  output logic                overflow,
  video_pattern_src_if.master rd_if
);
  localparam int H_TOT = H_ACT + H_BLANK;
  localparam int V_TOT = V_ACT + V_BLANK;
  localparam int HW    = ($clog2(H_TOT) > 8) ? $clog2(H_TOT) : 8;
  localparam int VW    = ($clog2(V_TOT) > 1) ? $clog2(V_TOT) : 1;
  localparam int BAR_W = H_ACT / 8;
  localparam int UW    = FIFO_AW + 1;

  logic [1:0]    wr_rst_q, rd_rst_q;
  logic          wr_rstn, rd_rstn;
  tg_state_e     state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          run, h_last, v_last, frame_end, de, first_pix;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] solid_q, solid_d, cnt_q, cnt_d, cnt_base, pix;
  logic [2:0]    bar_idx;
  logic          wr_vld_q, wr_vld_d, wr_sof_q, wr_sof_d;
  logic [DW-1:0] wr_pix_q, wr_pix_d;
  logic          drop_q, drop_d, ovf_q, ovf_d, fifo_we, fifo_full;
  logic [DW:0]   fifo_rdata;
  logic [UW-1:0] fifo_usedw;
  logic          burst_q, burst_d;

  // Reset synchronisers: assert immediately, release on the local clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wr_rst_q <= 2'b00;
    else       wr_rst_q <= {wr_rst_q[0], 1'b1};
  end

  // Same for the read domain.
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) rd_rst_q <= 2'b00;
    else       rd_rst_q <= {rd_rst_q[0], 1'b1};
  end

  assign wr_rstn = wr_rst_q[1];
  assign rd_rstn = rd_rst_q[1];

  // Timing generator state register.
  always_ff @(posedge clk or negedge wr_rstn) begin
    if (!wr_rstn) state_q <= TG_IDLE;
    else          state_q <= state_d;
  end

  // Once started a frame always completes; enable is only looked at on frame boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TG_IDLE: if (enable) state_d = TG_RUN;
      TG_RUN:  if (frame_end && !enable) state_d = TG_IDLE;
      default: state_d = TG_IDLE;
    endcase
  end

  // FSM outputs: raster position flags and active-video.
  always_comb begin
    run       = (state_q == TG_RUN);
    h_last    = (h_q == HW'(H_TOT - 1));
    v_last    = (v_q == VW'(V_TOT - 1));
    frame_end = run && h_last && v_last;
    de        = run && (h_q < HW'(H_ACT)) && (v_q < VW'(V_ACT));
    first_pix = de && (h_q == '0) && (v_q == '0);
  end

  // Raster counters advance only while a frame is running.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (run) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Pattern selection; mode/colour are captured on the first pixel and held for the frame.
  always_comb begin
    mode_d   = first_pix ? mode_e'(mode) : mode_q;
    solid_d  = first_pix ? solid_color : solid_q;
    cnt_base = first_pix ? '0 : cnt_q;
    cnt_d    = de ? cnt_base + 1'b1 : cnt_q;
    bar_idx  = 3'(h_q / HW'(BAR_W));
    case (mode_d)
      MODE_BARS:  pix = DW'(bar_color(bar_idx));
      MODE_RAMP:  pix = {(DW/8){h_q[7:0]}};
      MODE_COUNT: pix = cnt_base;
      default:    pix = solid_d;
    endcase
  end

  // Write stage: a frame that hits a full FIFO is dropped until the next frame start.
  always_comb begin
    wr_vld_d = de;
    wr_sof_d = first_pix;
    wr_pix_d = de ? pix : wr_pix_q;
    fifo_we  = 1'b0;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (wr_vld_q) begin
      if (fifo_full) begin
        ovf_d  = 1'b1;
        drop_d = 1'b1;
      end else if (wr_sof_q || !drop_q) begin
        fifo_we = 1'b1;
        drop_d  = 1'b0;
      end
    end
  end

  // Write-domain registers.
  always_ff @(posedge clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      h_q      <= '0;
      v_q      <= '0;
      mode_q   <= MODE_BARS;
      solid_q  <= '0;
      cnt_q    <= '0;
      wr_vld_q <= 1'b0;
      wr_sof_q <= 1'b0;
      wr_pix_q <= '0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      cnt_q    <= cnt_d;
      wr_vld_q <= wr_vld_d;
      wr_sof_q <= wr_sof_d;
      wr_pix_q <= wr_pix_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  pix_async_fifo #(.W(DW + 1), .AW(FIFO_AW)) u_fifo (
    .wr_clk   (clk),
    .wr_rstn  (wr_rstn),
    .wr_en    (fifo_we),
    .wr_data  ({wr_sof_q, wr_pix_q}),
    .wr_full  (fifo_full),
    .rd_clk   (rd_clk),
    .rd_rstn  (rd_rstn),
    .rd_req   (rd_if.rd_req),
    .rd_data  (fifo_rdata),
    .rd_usedw (fifo_usedw)
  );

  // Burst-ready threshold on the read side.
  always_comb burst_d = (fifo_usedw >= UW'(BURST_LEN));

  // Burst-ready register.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) burst_q <= 1'b0;
    else          burst_q <= burst_d;
  end

  assign overflow        = ovf_q;
  assign rd_if.rd_data   = fifo_rdata[DW-1:0];
  assign rd_if.rd_sof    = fifo_rdata[DW];
  assign rd_if.rd_usedw  = fifo_usedw;
  assign rd_if.burst_rdy = burst_q;
endmodule

// File: doc/video_pattern_src.md
VIDEO_PATTERN_SRC -- requirements
Module: video_pattern_src

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DW  24  pixel width; multiple of 8, >=24
  H_ACT  1280  active pixels/line (multiple of 8)
  H_BLANK  370  blanking pixels/line
  V_ACT  720  active lines/frame
  V_BLANK  30  blanking lines/frame
  FIFO_AW  8  FIFO address width; depth 2^FIFO_AW
  BURST_LEN  64  words needed for burst_rdy; <= 2^FIFO_AW
REQ-002 Ports (name direction width meaning):
  clk  in  1  pixel clock, write domain
  rstn  in  1  reset, asynchronous, active-low
  rd_clk  in  1  memory-side read clock
  enable  in  1  clk domain; run timing generator
  mode  in  2  clk domain; 0 colour bars, 1 ramp, 2 counter, 3 solid
  solid_color  in  DW  clk domain; mode-3 pixel value
  overflow  out  1  clk domain; sticky, FIFO write attempted while full
  rd_req  in  1  rd_clk domain; pop one word
  rd_data  out  DW  rd_clk domain; popped pixel
  rd_sof  out  1  rd_clk domain; rd_data is first pixel of a frame
  rd_usedw  out  FIFO_AW+1  rd_clk domain; words available
  burst_rdy  out  1  rd_clk domain; rd_usedw >= BURST_LEN
REQ-003 Reset rstn, asynchronous, active-low; clock clk (write domain), plus rd_clk (read domain).

Function
REQ-004 h_cnt counts 0..H_ACT+H_BLANK-1 and wraps; v_cnt increments on h_cnt wrap, counts 0..V_ACT+V_BLANK-1, wraps.
REQ-005 de = (h_cnt < H_ACT) && (v_cnt < V_ACT); each de cycle produces one pixel, written to FIFO the following clk cycle.
REQ-006 enable low: current frame completes, counters then hold at h=v=0 with no writes; enable high at h=v=0 starts the frame next cycle.
REQ-007 mode and solid_color sampled only at h=v=0; mid-frame changes take effect next frame.
REQ-008 Mode 0: 8 bars of H_ACT/8 pixels, in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 in bits [23:0]; bits above 23 zero.
REQ-009 Mode 1: every byte lane = h_cnt[7:0]. Mode 2: per-frame word counter from 0, +1 per pixel, mod 2^DW. Mode 3: solid_color.
REQ-010 FIFO entry = {sof, pixel}; sof = 1 only for pixel at h=v=0.
REQ-011 Write while full: word dropped, overflow set; all further pixels of that frame dropped; writing resumes at next frame's first pixel if not full.
REQ-012 overflow cleared only by reset.
REQ-013 Read: rd_req with FIFO non-empty pops; rd_data/rd_sof valid and registered 1 rd_clk cycle after rd_req; hold otherwise.
REQ-014 rd_req while empty ignored: no pointer change, rd_data holds.
REQ-015 rd_usedw from 2-flop-synchronised Gray write pointer; may under-report (<=3 rd_clk latency), never over-report; range 0..2^FIFO_AW.
REQ-016 burst_rdy registered from rd_usedw, rises 1 rd_clk after rd_usedw reaches BURST_LEN.
REQ-017 Write-side full from synchronised Gray read pointer; conservative, never overwrites unread data.

Reset
REQ-018 rstn asserts asynchronously in both domains; deassertion synchronised per domain by 2-flop synchroniser.
REQ-019 Reset values: h_cnt=v_cnt=0, pointers 0, overflow=0, rd_data=0, rd_sof=0, rd_usedw=0, burst_rdy=0; reset mid-frame discards FIFO contents and restarts at h=v=0.

Structure
REQ-020 Shared package holds mode encodings, 8-entry bar colour table, and Gray-conversion functions.
REQ-021 One sub-module, pix_async_fifo (DW+1 wide, 2^FIFO_AW deep, Gray pointers, usedw/full/empty); timing, pattern and drop logic in top.

Verification (DW=24, H_ACT=16, H_BLANK=4, V_ACT=4, V_BLANK=2, FIFO_AW=4, BURST_LEN=8)
REQ-022 mode=2, reader pops whenever non-empty -> 64 words/frame, values 0..63, rd_sof only with 0, overflow=0.
REQ-023 mode=0 -> each line 2 pixels each of FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-024 mode=2, no reads -> 16 words stored, overflow=1, remaining 48 dropped; after drain, next word read is 0 with rd_sof=1.
REQ-025 mode 3 -> 2 at mid-frame -> frame finishes solid_color; next frame counts from 0.
REQ-026 Empty FIFO, rd_req=1 -> rd_data holds, rd_usedw=0; burst_rdy=1 within 1 rd_clk of rd_usedw=8.
REQ-027 rstn pulsed mid-frame -> all outputs at reset values; first word afterwards is 0 with rd_sof=1.
